cache_axi_bridge: RTL and testbench

Memory-side responder for cache miss/write-through requests (m_strobe/m_ready handshake); converts each request

---
 rtl/cache_axi_bridge_pkg.sv | 27 ++
 rtl/cache_axi_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cache_axi_bridge_pkg
// Shared definitions for the cache-to-AXI bridge: FSM state encoding, the AXI
// OKAY response code and a helper that classifies a response as an error.
// -----------------------------------------------------------------------------
package cache_axi_bridge_pkg;

    // One outstanding transaction at a time; the FSM walks the read or the
    // write path and always finishes in DONE for the single completion pulse.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY on a non-exclusive
    // access) is reported to the cache as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/cache_axi_bridge.sv
// -----------------------------------------------------------------------------
// cache_axi_bridge
// Memory-side responder for cache miss / write-through requests. Each request
// on the m_strobe/m_ready handshake becomes exactly one single-beat AXI4 read
// (AR/R) or write (AW/W/B). AXI len/size/burst/id are tied off outside.
//
// Ports
//   clk, clrn            clock (rising edge), asynchronous active-low reset
//   m_strobe, m_rw       request valid (held until m_ready), 0=read 1=write
//   m_a, m_din, m_sel    address, write data, byte enables (sampled in IDLE)
//   m_dout               last read data, held until the next read completes
//   m_ready, m_err       one-cycle completion pulse and its error flag
//   ar*/r*               AXI read address / read data channels
//   aw*/w*/b*            AXI write address / write data / write response
// -----------------------------------------------------------------------------
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,
    // cache side
    input  logic               m_strobe,
    input  logic               m_rw,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    input  logic [3:0]         m_sel,
    output logic [31:0]        m_dout,
    output logic               m_ready,
    output logic               m_err,
    // AXI read address
    output logic [A_WIDTH-1:0] araddr,
    output logic               arvalid,
    input  logic               arready,
    // AXI read data
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready,
    // AXI write address
    output logic [A_WIDTH-1:0] awaddr,
    output logic               awvalid,
    input  logic               awready,
    // AXI write data
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wvalid,
    input  logic               wready,
    // AXI write response
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_dout;
    logic [A_WIDTH-1:0] r_araddr;
    logic [A_WIDTH-1:0] r_awaddr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_err;
    logic               r_aw_done;
    logic               r_w_done;

    logic               w_start;
    logic               w_awvalid;
    logic               w_wvalid;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_aw_fin;
    logic               w_w_fin;
    logic               w_r_hs;
    logic               w_b_hs;

    // A new request is only accepted in IDLE; during DONE m_strobe is ignored
    // so a strobe held high simply starts the next request one cycle later.
    assign w_start   = (r_state == S_IDLE) && m_strobe;

    // AW and W are raised together on entry to WR_REQ and each drops on its own
    // handshake. The valids depend only on registered state, never on ready.
    assign w_awvalid = (r_state == S_WR_REQ) && !r_aw_done;
    assign w_wvalid  = (r_state == S_WR_REQ) && !r_w_done;
    assign w_aw_hs   = w_awvalid && awready;
    assign w_w_hs    = w_wvalid  && wready;
    assign w_aw_fin  = r_aw_done || w_aw_hs;
    assign w_w_fin   = r_w_done  || w_w_hs;

    assign w_r_hs    = (r_state == S_RD_DATA) && rvalid;
    assign w_b_hs    = (r_state == S_WR_RESP) && bvalid;

    assign awvalid   = w_awvalid;
    assign wvalid    = w_wvalid;
    assign araddr    = r_araddr;
    assign awaddr    = r_awaddr;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign m_dout    = r_dout;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        bready  = 1'b0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m_strobe) begin
                    w_next = m_rw ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_WR_REQ: begin
                // Both handshakes may land in the same cycle or in either order.
                if (w_aw_fin && w_w_fin) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                m_ready = 1'b1;
                m_err   = r_err;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Request capture, write-channel bookkeeping and response capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_dout    <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_start) begin
                // Request fields are frozen here; later m_a/m_din changes
                // while busy do not reach the AXI side.
                if (m_rw) begin
                    r_awaddr <= m_a;
                    r_wdata  <= m_din;
                    r_wstrb  <= m_sel;
                end else begin
                    r_araddr <= m_a;
                end
                r_err     <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end

            if (w_r_hs) begin
                r_dout <= rdata;
                r_err  <= resp_is_err(rresp);
            end
            if (w_b_hs) begin
                r_err <= resp_is_err(bresp);
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        m_strobe = 1'b0;
    logic        m_rw = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_din = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_dout;
    logic        m_ready, m_err;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    // slave behaviour knobs, set by the stimulus
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] rdata_v = '0;
    logic [1:0]  rresp_v = 2'b00;
    logic [1:0]  bresp_v = 2'b00;

    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;

    // monitors
    int          cyc_ctr = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    int          aw_stamp = 0, w_stamp = 0;
    logic [31:0] ar_cap = '0, aw_cap = '0, wd_cap = '0;
    logic [3:0]  ws_cap = '0;
    logic        ar_pend = 1'b0;
    logic        ar_drop = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          lat;
        logic [31:0] dout;
        logic        err;
    } exp_t;
    exp_t sb[$];

    cache_axi_bridge #(.A_WIDTH(32)) dut (
        .clk(clk), .clrn(clrn),
        .m_strobe(m_strobe), .m_rw(m_rw), .m_a(m_a), .m_din(m_din), .m_sel(m_sel),
        .m_dout(m_dout), .m_ready(m_ready), .m_err(m_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Slave: each ready/valid rises after the configured number of wait cycles.
    assign arready = arvalid && (ar_wait >= ar_delay);
    assign rvalid  = rready  && (r_wait  >= r_delay);
    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid  && (w_wait  >= w_delay);
    assign bvalid  = bready  && (b_wait  >= b_delay);
    assign rdata   = rdata_v;
    assign rresp   = rresp_v;
    assign bresp   = bresp_v;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ar_wait <= 0; r_wait <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
            ar_pend <= 1'b0;
        end else begin
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            r_wait  <= (rready  && !rvalid)  ? r_wait  + 1 : 0;
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid  && !wready)  ? w_wait  + 1 : 0;
            b_wait  <= (bready  && !bvalid)  ? b_wait  + 1 : 0;
            ar_pend <= arvalid && !arready;
        end
    end

    always @(posedge clk) begin
        cyc_ctr <= cyc_ctr + 1;
        if (arvalid && arready) begin ar_cnt <= ar_cnt + 1; ar_cap <= araddr; end
        if (awvalid && awready) begin aw_cnt <= aw_cnt + 1; aw_cap <= awaddr; aw_stamp <= cyc_ctr; end
        if (wvalid && wready) begin
            w_cnt <= w_cnt + 1; wd_cap <= wdata; ws_cap <= wstrb; w_stamp <= cyc_ctr;
        end
    end

    // An address valid that was waiting must not fall before its ready.
    always @(negedge clk) begin
        if (clrn && ar_pend && !arvalid) ar_drop <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives one request from a negedge, waits (bounded) for m_ready and
    // checks latency / data / error against the scoreboard entry.
    task automatic run_req(input string tag, input logic rw, input logic [31:0] a,
                           input logic [31:0] din, input logic [3:0] sel,
                           input int lat, input logic [31:0] dout, input logic err);
        exp_t e;
        int   cyc;
        sb.push_back('{lat, dout, err});
        m_strobe = 1'b1; m_rw = rw; m_a = a; m_din = din; m_sel = sel;
        @(negedge clk);
        // changes while busy must be ignored
        m_a = ~a; m_din = ~din; m_sel = ~sel;
        cyc = 1;
        while (!m_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        m_strobe = 1'b0;
        e = sb.pop_front();
        chk({tag, ".lat"}, cyc, e.lat);
        chk({tag, ".dout"}, m_dout, e.dout);
        chk({tag, ".err"}, {31'd0, m_err}, {31'd0, e.err});
        @(negedge clk);
        chk({tag, ".single_pulse"}, {31'd0, m_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0, w0, cyc;
        exp_t e;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst.m_ready", {31'd0, m_ready}, 32'd0);
        chk("rst.m_err",   {31'd0, m_err}, 32'd0);
        chk("rst.m_dout",  m_dout, 32'd0);
        chk("rst.valids",  {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst.araddr",  araddr, 32'd0);
        chk("rst.awaddr",  awaddr, 32'd0);
        chk("rst.wdata",   wdata, 32'd0);
        chk("rst.wstrb",   {28'd0, wstrb}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // ---------------- zero-wait read ----------------
        a0 = ar_cnt;
        rdata_v = 32'hDEAD_BEEF;
        run_req("rd0", 1'b0, 32'h1FC0_0000, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0);
        chk("rd0.ar_count", ar_cnt - a0, 32'd1);
        chk("rd0.araddr", ar_cap, 32'h1FC0_0000);

        // ---------------- stalled read ----------------
        a0 = ar_cnt;
        ar_delay = 4; r_delay = 2; rdata_v = 32'hCAFE_F00D;
        run_req("rd_stall", 1'b0, 32'h1FC0_0010, 32'h0, 4'h0, 9, 32'hCAFE_F00D, 1'b0);
        chk("rd_stall.ar_count", ar_cnt - a0, 32'd1);
        chk("rd_stall.arvalid_stable", {31'd0, ar_drop}, 32'd0);
        ar_delay = 0; r_delay = 0;

        // ---------------- write, W before AW ----------------
        a0 = aw_cnt; w0 = w_cnt;
        aw_delay = 2; w_delay = 0;
        run_req("wr0", 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 5, 32'hCAFE_F00D, 1'b0);
        chk("wr0.aw_count", aw_cnt - a0, 32'd1);
        chk("wr0.w_count", w_cnt - w0, 32'd1);
        chk("wr0.awaddr", aw_cap, 32'h8000_0004);
        chk("wr0.wdata", wd_cap, 32'h1234_5678);
        chk("wr0.wstrb", {28'd0, ws_cap}, 32'h3);
        chk("wr0.w_before_aw", {31'd0, (w_stamp < aw_stamp)}, 32'd1);
        aw_delay = 0;

        // ---------------- read error then OKAY read ----------------
        rresp_v = 2'b10; rdata_v = 32'h0BAD_F00D;
        run_req("rd_err", 1'b0, 32'h1000_0000, 32'h0, 4'h0, 3, 32'h0BAD_F00D, 1'b1);
        rresp_v = 2'b00; rdata_v = 32'h600D_D00D;
        run_req("rd_ok", 1'b0, 32'h1000_0004, 32'h0, 4'h0, 3, 32'h600D_D00D, 1'b0);

        // ---------------- write error, AW before W ----------------
        bresp_v = 2'b11; w_delay = 1;
        run_req("wr_err", 1'b1, 32'h2000_0000, 32'hA5A5_5A5A, 4'b1111, 4, 32'h600D_D00D, 1'b1);
        chk("wr_err.wdata", wd_cap, 32'hA5A5_5A5A);
        bresp_v = 2'b00; w_delay = 0;

        // ---------------- reset abort in RD_DATA ----------------
        r_delay = 20;
        m_strobe = 1'b1; m_rw = 1'b0; m_a = 32'h3000_0000;
        cyc = 0;
        while (!rready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort.reached_rd_data", {31'd0, rready}, 32'd1);
        clrn = 1'b0; m_strobe = 1'b0;
        #1;
        chk("abort.valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, m_ready}, 32'd0);
        @(negedge clk);
        clrn = 1'b1; r_delay = 0;
        @(negedge clk);
        rdata_v = 32'h5555_AAAA;
        run_req("post_abort", 1'b0, 32'h3000_0004, 32'h0, 4'h0, 3, 32'h5555_AAAA, 1'b0);

        // ---------------- back-to-back, strobe held through DONE ----------------
        sb.push_back('{3, 32'h1111_1111, 1'b0});
        sb.push_back('{4, 32'h2222_2222, 1'b0});
        rdata_v = 32'h1111_1111;
        m_strobe = 1'b1; m_rw = 1'b0; m_a = 32'h4000_0000;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!m_ready && cyc < 100);
        e = sb.pop_front();
        chk("b2b_1.lat", cyc, e.lat);
        chk("b2b_1.dout", m_dout, e.dout);
        rdata_v = 32'h2222_2222;
        @(negedge clk);
        chk("b2b.not_adjacent", {31'd0, m_ready}, 32'd0);
        cyc = 1;
        while (!m_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        m_strobe = 1'b0;
        e = sb.pop_front();
        chk("b2b_2.lat", cyc, e.lat);
        chk("b2b_2.dout", m_dout, e.dout);
        chk("b2b_2.err", {31'd0, m_err}, {31'd0, e.err});
        @(negedge clk);
        chk("b2b_2.single_pulse", {31'd0, m_ready}, 32'd0);
        chk("sb.empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
